// File: rtl/brownout_pkg.sv
// Shared types and default constants for the brownout detector back end.
package brownout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GOOD,
    ST_DEBOUNCE_LOW,
    ST_BROWN,
    ST_DEBOUNCE_HIGH,
    ST_HOLD
  } brownout_state_t;

  localparam int unsigned DEF_SETTLE_CYCLES  = 64;
  localparam int unsigned DEF_ASSERT_CYCLES  = 4;
  localparam int unsigned DEF_RELEASE_CYCLES = 16;
  localparam int unsigned DEF_HOLD_CYCLES    = 256;
  localparam int unsigned DEF_CNT_W          = 16;
  localparam int unsigned EVT_CNT_W          = 8;

endpackage

// File: rtl/brownout_sync.sv
// Two-flop synchronizer with asynchronous active-low reset to a configurable value.
module brownout_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/brownout_ctrl.sv
// Brownout detector back end: comparator enable, settling, debounce, release hold-off, irq.
// Optional saturating event counter port enabled by BROWNOUT_EVENT_CNT_EN.
module brownout_ctrl
  import brownout_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned ASSERT_CYCLES  = DEF_ASSERT_CYCLES,
  parameter int unsigned RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic comp_dout,
  output logic comp_ena,
  output logic ready,
  output logic brout_filt,
  output logic brout_irq
`ifdef BROWNOUT_EVENT_CNT_EN
  ,
  output logic [EVT_CNT_W-1:0] event_cnt
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  brownout_state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic comp_s;
  logic irq_nxt;

  brownout_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (comp_dout),
    .q     (comp_s)
  );

  // cnt_nxt defaults to zero so every state change clears the counter.
  always_comb begin
    nxt     = state;
    cnt_nxt = '0;
    if (!ena) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: nxt = ST_SETTLE;
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            if (comp_s) begin
              nxt = ST_GOOD;
            end else if (ASSERT_CYCLES == 1) begin
              nxt = ST_BROWN;
            end else begin
              nxt     = ST_DEBOUNCE_LOW;
              cnt_nxt = CNT_ONE;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_GOOD: begin
          if (!comp_s) begin
            if (ASSERT_CYCLES == 1) begin
              nxt = ST_BROWN;
            end else begin
              nxt     = ST_DEBOUNCE_LOW;
              cnt_nxt = CNT_ONE;
            end
          end
        end
        ST_DEBOUNCE_LOW: begin
          if (comp_s)                  nxt = ST_GOOD;
          else if (cnt == ASSERT_LAST) nxt = ST_BROWN;
          else                         cnt_nxt = cnt + CNT_ONE;
        end
        ST_BROWN: begin
          if (comp_s) begin
            if (RELEASE_CYCLES == 1) begin
              nxt = ST_HOLD;
            end else begin
              nxt     = ST_DEBOUNCE_HIGH;
              cnt_nxt = CNT_ONE;
            end
          end
        end
        ST_DEBOUNCE_HIGH: begin
          if (!comp_s)                  nxt = ST_BROWN;
          else if (cnt == RELEASE_LAST) nxt = ST_HOLD;
          else                          cnt_nxt = cnt + CNT_ONE;
        end
        ST_HOLD: begin
          if (!comp_s)               nxt = ST_BROWN;
          else if (cnt == HOLD_LAST) nxt = ST_GOOD;
          else                       cnt_nxt = cnt + CNT_ONE;
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  // Only a fresh assertion raises the interrupt; re-entry from release does not.
  always_comb begin
    irq_nxt = (nxt == ST_BROWN) &&
              (state inside {ST_SETTLE, ST_GOOD, ST_DEBOUNCE_LOW});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      comp_ena   <= 1'b0;
      ready      <= 1'b0;
      brout_filt <= 1'b0;
      brout_irq  <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_nxt;
      comp_ena   <= (nxt != ST_IDLE);
      ready      <= nxt inside {ST_GOOD, ST_DEBOUNCE_LOW, ST_BROWN,
                                ST_DEBOUNCE_HIGH, ST_HOLD};
      brout_filt <= nxt inside {ST_BROWN, ST_DEBOUNCE_HIGH, ST_HOLD};
      brout_irq  <= irq_nxt;
    end
  end

`ifdef BROWNOUT_EVENT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_cnt <= '0;
    end else if (irq_nxt && (event_cnt != '1)) begin
      event_cnt <= event_cnt + EVT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_brownout_ctrl.sv
// Randomized bench for brownout_ctrl against a run-length reference model.
// Event counter checks follow BROWNOUT_EVENT_CNT_EN.
module tb_brownout_ctrl;

  localparam int unsigned SETTLE  = 64;
  localparam int unsigned ASSERTN = 4;
  localparam int unsigned RELEASE = 16;
  localparam int unsigned HOLD    = 256;

  logic clk = 1'b0;
  logic rst_n, ena, comp_dout;
  logic comp_ena, ready, brout_filt, brout_irq;
`ifdef BROWNOUT_EVENT_CNT_EN
  logic [7:0] event_cnt;
`endif

  always #5 clk = ~clk;

  brownout_ctrl #(
    .SETTLE_CYCLES  (SETTLE),
    .ASSERT_CYCLES  (ASSERTN),
    .RELEASE_CYCLES (RELEASE),
    .HOLD_CYCLES    (HOLD),
    .CNT_W          (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .comp_dout  (comp_dout),
    .comp_ena   (comp_ena),
    .ready      (ready),
    .brout_filt (brout_filt),
    .brout_irq  (brout_irq)
`ifdef BROWNOUT_EVENT_CNT_EN
    ,
    .event_cnt  (event_cnt)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: behaviour expressed as "enabled age" and run lengths of
  // consecutive synchronized samples at the level opposing the current flag.
  logic        sq[$];
  bit          m_active, m_brown, m_irq;
  int unsigned m_age, m_run, m_evt;

  function automatic void m_reset();
    sq = {1'b1, 1'b1};
    m_active = 0; m_brown = 0; m_irq = 0;
    m_age = 0; m_run = 0; m_evt = 0;
  endfunction

  function automatic void m_judge(input logic s);
    if (!m_brown) begin
      if (!s) begin
        m_run++;
        if (m_run == ASSERTN) begin
          m_brown = 1; m_run = 0; m_irq = 1;
          if (m_evt < 255) m_evt++;
        end
      end else m_run = 0;
    end else begin
      if (s) begin
        m_run++;
        if (m_run == RELEASE + HOLD) begin m_brown = 0; m_run = 0; end
      end else m_run = 0;
    end
  endfunction

  function automatic void m_edge();
    logic s;
    if (!rst_n) begin
      m_reset();
      return;
    end
    s = sq.pop_front();
    sq.push_back(comp_dout);
    m_irq = 0;
    if (!ena) begin
      m_active = 0; m_brown = 0; m_run = 0; m_age = 0;
    end else if (!m_active) begin
      m_active = 1; m_age = 0;
    end else begin
      if (m_age < SETTLE) m_age++;
      if (m_age == SETTLE) m_judge(s);
    end
  endfunction

  task automatic check_all(input string phase);
    check_eq({phase, ".comp_ena"},   32'(comp_ena),   32'(m_active));
    check_eq({phase, ".ready"},      32'(ready),      32'(m_active && m_age == SETTLE));
    check_eq({phase, ".brout_filt"}, 32'(brout_filt), 32'(m_brown));
    check_eq({phase, ".brout_irq"},  32'(brout_irq),  32'(m_irq));
`ifdef BROWNOUT_EVENT_CNT_EN
    check_eq({phase, ".event_cnt"},  32'(event_cnt),  32'(m_evt));
`endif
  endtask

  string phase = "reset";

  task automatic step();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    check_all(phase);
  endtask

  task automatic drive_run(input logic lvl, input int unsigned n);
    comp_dout = lvl;
    repeat (n) step();
  endtask

  initial begin
    m_reset();
    rst_n = 1'b0; ena = 1'b0; comp_dout = 1'b1;
    step(); step();

    phase = "enable";
    ena = 1'b1;
    step();
    rst_n = 1'b1;
    drive_run(1'b1, SETTLE + 10);

    phase = "assert";
    drive_run(1'b0, 12);
    phase = "release";
    drive_run(1'b1, RELEASE + HOLD + 10);

    phase = "glitch";
    drive_run(1'b0, 3);
    drive_run(1'b1, 20);

    phase = "hold_glitch";
    drive_run(1'b0, 10);
    drive_run(1'b1, 100);
    drive_run(1'b0, 1);
    drive_run(1'b1, RELEASE + HOLD + 10);

    phase = "ena_drop";
    drive_run(1'b0, 10);
    ena = 1'b0;
    step(); step();
    ena = 1'b1;
    drive_run(1'b1, SETTLE + 5);

    phase = "random";
    for (int i = 0; i < 40; i++) begin
      int unsigned sel, len;
      sel = $urandom_range(0, 3);
      case (sel)
        0: len = $urandom_range(1, 6);
        1: len = $urandom_range(10, 40);
        2: len = $urandom_range(260, 300);
        default: len = 0;
      endcase
      if (sel == 3) begin
        for (int k = 0; k < 50; k++) begin
          comp_dout = 1'($urandom_range(0, 1));
          step();
        end
      end else begin
        drive_run(1'($urandom_range(0, 1)), len);
      end
      if ($urandom_range(0, 7) == 0) begin
        ena = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        ena = 1'b1;
      end
    end

`ifdef BROWNOUT_EVENT_CNT_EN
    phase = "saturate";
    for (int i = 0; i < 300; i++) begin
      comp_dout = 1'b0;
      ena = 1'b0;
      step();
      ena = 1'b1;
      repeat (SETTLE + ASSERTN) step();
    end
    check_eq("saturate.final", 32'(event_cnt), 32'd255);
`endif

    phase = "async_rst";
    drive_run(1'b1, SETTLE + 10);
    drive_run(1'b0, 3);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_all("async_rst.now");
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;
    drive_run(1'b1, SETTLE + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
